// File: rtl/block_execution_controller.sv
// Run sequencer for the TIA block: reset/arm/execute, then wait for stable
// halt + quiescence and report completion, timeout or abort.
module block_execution_controller #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COUNTER_WIDTH-1:0] timeout_limit,
  output logic                     block_reset,
  output logic                     block_enable,
  output logic                     block_execute,
  input  logic                     block_halted,
  input  logic                     block_channels_quiescent,
  input  logic                     block_routers_quiescent,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic [COUNTER_WIDTH-1:0] cycle_count
);

  localparam int unsigned RST_CNT_W = $clog2(RESET_CYCLES);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] STATUS_NONE    = 2'b00;
  localparam logic [1:0] STATUS_DONE    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [1:0] STATUS_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET_BLOCK = 3'd1,
    ST_ARM         = 3'd2,
    ST_RUN         = 3'd3,
    ST_FINISH      = 3'd4
  } state_t;

  state_t                   r_state;
  logic [RST_CNT_W-1:0]     r_rst_cnt;
  logic [SETTLE_W-1:0]      r_settle;
  logic [COUNTER_WIDTH-1:0] r_limit;
  logic [COUNTER_WIDTH-1:0] r_cycle_count;
  logic [1:0]               r_status;
  logic                     r_block_reset;
  logic                     r_block_enable;
  logic                     r_block_execute;
  logic                     r_busy;
  logic                     r_done;

  state_t                   w_state;
  logic [RST_CNT_W-1:0]     w_rst_cnt;
  logic [SETTLE_W-1:0]      w_settle;
  logic [COUNTER_WIDTH-1:0] w_limit;
  logic [COUNTER_WIDTH-1:0] w_cycle_count;
  logic [COUNTER_WIDTH-1:0] w_cycle_inc;
  logic [1:0]               w_status;
  logic                     w_block_reset;
  logic                     w_block_enable;
  logic                     w_block_execute;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_all_ok;

  // State and all output/bookkeeping registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_rst_cnt       <= '0;
      r_settle        <= '0;
      r_limit         <= '0;
      r_cycle_count   <= '0;
      r_status        <= STATUS_NONE;
      r_block_reset   <= 1'b0;
      r_block_enable  <= 1'b0;
      r_block_execute <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_rst_cnt       <= w_rst_cnt;
      r_settle        <= w_settle;
      r_limit         <= w_limit;
      r_cycle_count   <= w_cycle_count;
      r_status        <= w_status;
      r_block_reset   <= w_block_reset;
      r_block_enable  <= w_block_enable;
      r_block_execute <= w_block_execute;
      r_busy          <= w_busy;
      r_done          <= w_done;
    end
  end

  // Next-state, counters and registered-output decode from the next state.
  always_comb begin
    w_state         = r_state;
    w_rst_cnt       = r_rst_cnt;
    w_settle        = '0;
    w_limit         = r_limit;
    w_cycle_count   = r_cycle_count;
    w_status        = r_status;
    w_block_enable  = r_block_enable;
    w_block_reset   = 1'b0;
    w_block_execute = 1'b0;
    w_busy          = 1'b0;
    w_done          = 1'b0;

    w_all_ok    = block_halted && block_channels_quiescent && block_routers_quiescent;
    // Saturating increment so a no-timeout run never wraps the count.
    w_cycle_inc = (&r_cycle_count) ? r_cycle_count
                                   : r_cycle_count + COUNTER_WIDTH'(1);

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state       = ST_RESET_BLOCK;
          w_limit       = timeout_limit;
          w_cycle_count = '0;
          w_status      = STATUS_NONE;
          w_rst_cnt     = '0;
        end
      end
      ST_RESET_BLOCK: begin
        if (abort) begin
          w_state  = ST_FINISH;
          w_status = STATUS_ABORT;
        end else if (r_rst_cnt == RST_CNT_W'(RESET_CYCLES - 1)) begin
          w_state = ST_ARM;
        end else begin
          w_rst_cnt = r_rst_cnt + RST_CNT_W'(1);
        end
      end
      ST_ARM: begin
        if (abort) begin
          w_state  = ST_FINISH;
          w_status = STATUS_ABORT;
        end else begin
          w_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_cycle_count = w_cycle_inc;
        w_settle      = w_all_ok ? r_settle + SETTLE_W'(1) : '0;
        // Abort wins, then completion, then timeout.
        if (abort) begin
          w_state  = ST_FINISH;
          w_status = STATUS_ABORT;
        end else if (w_all_ok && (r_settle == SETTLE_W'(SETTLE_CYCLES - 1))) begin
          w_state  = ST_FINISH;
          w_status = STATUS_DONE;
        end else if ((r_limit != '0) && (w_cycle_inc == r_limit)) begin
          w_state  = ST_FINISH;
          w_status = STATUS_TIMEOUT;
        end
      end
      ST_FINISH: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Enable is held after a run so the host can reach block memories.
    case (w_state)
      ST_RESET_BLOCK: w_block_enable = 1'b0;
      ST_ARM,
      ST_RUN:         w_block_enable = 1'b1;
      default:        w_block_enable = r_block_enable;
    endcase
    w_block_reset   = (w_state == ST_RESET_BLOCK);
    w_block_execute = (w_state == ST_RUN);
    w_busy          = (w_state != ST_IDLE);
    w_done          = (w_state == ST_FINISH);
  end

  assign block_reset   = r_block_reset;
  assign block_enable  = r_block_enable;
  assign block_execute = r_block_execute;
  assign busy          = r_busy;
  assign done          = r_done;
  assign status        = r_status;
  assign cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_block_execution_controller.sv
// Randomised scoreboard bench for block_execution_controller.
module tb_block_execution_controller;

  localparam int CW      = 32;
  localparam int RC      = 4;
  localparam int SC      = 4;
  localparam int HORIZON = 20000;
  localparam int NEVER   = 1000000;
  localparam int NONE    = -1000;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] timeout_limit;
  logic          block_reset;
  logic          block_enable;
  logic          block_execute;
  logic          block_halted;
  logic          block_channels_quiescent;
  logic          block_routers_quiescent;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_count;

  block_execution_controller #(
    .COUNTER_WIDTH(CW),
    .RESET_CYCLES (RC),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .start                   (start),
    .abort                   (abort),
    .timeout_limit           (timeout_limit),
    .block_reset             (block_reset),
    .block_enable            (block_enable),
    .block_execute           (block_execute),
    .block_halted            (block_halted),
    .block_channels_quiescent(block_channels_quiescent),
    .block_routers_quiescent (block_routers_quiescent),
    .busy                    (busy),
    .done                    (done),
    .status                  (status),
    .cycle_count             (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]    st;
    logic [CW-1:0] cc;
    logic          en;
  } exp_t;
  exp_t sb[$];

  // Per-run scenario description (RUN cycles numbered from 0).
  int cfg_lim;
  bit cfg_mode1;
  int cfg_first;
  int cfg_glitch;
  bit rbits[256];
  bit cfg_has_abort;
  int cfg_abort_n;
  int cfg_start_p;
  bit cfg_start_abort;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit ok_at(input int n);
    if (n < 0) return 1'b0;
    if (cfg_mode1) return (n < 256) ? rbits[n] : 1'b0;
    return (n >= cfg_first) && (n != cfg_glitch);
  endfunction

  task automatic set_default();
    cfg_lim         = 0;
    cfg_mode1       = 1'b0;
    cfg_first       = NEVER;
    cfg_glitch      = -1;
    cfg_has_abort   = 1'b0;
    cfg_abort_n     = NONE;
    cfg_start_p     = -1;
    cfg_start_abort = 1'b0;
  endtask

  // Reference: walk RUN cycles applying abort > settle > timeout priority.
  task automatic model(output logic [1:0] st, output int cc, output bit en, output int n_end);
    int run_len;
    run_len = 0;
    st = 2'b00; cc = 0; en = 1'b1; n_end = NONE;
    if (cfg_has_abort && cfg_abort_n < 0) begin
      st = 2'b11; cc = 0; en = (cfg_abort_n == -1); n_end = cfg_abort_n;
      return;
    end
    for (int n = 0; n < HORIZON; n++) begin
      if (cfg_has_abort && cfg_abort_n == n) begin
        st = 2'b11; cc = n + 1; n_end = n; return;
      end
      run_len = ok_at(n) ? run_len + 1 : 0;
      if (run_len >= SC) begin
        st = 2'b01; cc = n + 1; n_end = n; return;
      end
      if (cfg_lim != 0 && n + 1 == cfg_lim) begin
        st = 2'b10; cc = n + 1; n_end = n; return;
      end
    end
  endtask

  task automatic drive_status(input bit ok);
    logic [2:0] v;
    if (ok) v = 3'b111;
    else    v = 3'($urandom_range(0, 6));
    block_halted             = v[2];
    block_channels_quiescent = v[1];
    block_routers_quiescent  = v[0];
  endtask

  // Drive one run from the current IDLE period and check per-cycle outputs.
  task automatic run_one();
    logic [1:0] st;
    int         cc;
    bit         en;
    int         n_end;
    int         p_f;
    int         n;
    exp_t       e;
    model(st, cc, en, n_end);
    if (n_end == NONE) begin
      cfg_lim = 300;
      model(st, cc, en, n_end);
    end
    p_f  = n_end + RC + 2;
    e.st = st; e.cc = CW'(cc); e.en = en;
    sb.push_back(e);

    start         = 1'b1;
    abort         = cfg_start_abort;
    timeout_limit = CW'(cfg_lim);
    drive_status(1'b0);
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int p = 0; p <= p_f; p++) begin
      n = p - RC - 1;
      if (p == p_f) begin
        chk("done_pulse", 64'(done), 64'(1));
      end else begin
        chk("done_low",      64'(done),          64'(0));
        chk("busy",          64'(busy),          64'(1));
        chk("block_reset",   64'(block_reset),   64'(p < RC));
        chk("block_enable",  64'(block_enable),  64'(p >= RC));
        chk("block_execute", 64'(block_execute), 64'(p >= RC + 1));
        chk("run_status",    64'(status),        64'(0));
        chk("run_count",     64'(cycle_count),   64'((n > 0) ? n : 0));
      end
      abort = cfg_has_abort && (n == cfg_abort_n) && (p < p_f);
      start = (p == cfg_start_p);
      drive_status(ok_at(n));
      @(posedge clock); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_done at %0t: got no done expected status %0h", $time, sb[0].st);
      sb.delete();
    end
    chk("idle_busy",    64'(busy),          64'(0));
    chk("idle_done",    64'(done),          64'(0));
    chk("idle_execute", 64'(block_execute), 64'(0));
    chk("idle_enable",  64'(block_enable),  64'(en));
    chk("idle_status",  64'(status),        64'(st));
    chk("idle_count",   64'(cycle_count),   64'(cc));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_block_reset"},   64'(block_reset),   64'(0));
    chk({tag, "_block_enable"},  64'(block_enable),  64'(0));
    chk({tag, "_block_execute"}, 64'(block_execute), 64'(0));
    chk({tag, "_busy"},          64'(busy),          64'(0));
    chk({tag, "_done"},          64'(done),          64'(0));
    chk({tag, "_status"},        64'(status),        64'(0));
    chk({tag, "_cycle_count"},   64'(cycle_count),   64'(0));
  endtask

  // Scoreboard monitor: compare the completion report whenever done is seen.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_done at %0t: got done=1 expected no pending run", $time);
      end else begin
        e = sb.pop_front();
        chk("status",        64'(status),        64'(e.st));
        chk("cycle_count",   64'(cycle_count),   64'(e.cc));
        chk("fin_enable",    64'(block_enable),  64'(e.en));
        chk("fin_execute",   64'(block_execute), 64'(0));
        chk("fin_busy",      64'(busy),          64'(1));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    timeout_limit = '0;
    drive_status(1'b0);
    #1 reset = 1'b0;
    #2 check_all_zero("por");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // Abort alone in IDLE does nothing.
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'(0));
    chk("idle_abort_done", 64'(done), 64'(0));

    set_default(); cfg_first = 20;                          run_one();
    set_default(); cfg_first = 10; cfg_glitch = 13;         run_one();
    set_default(); cfg_lim = 100;                           run_one();
    set_default(); cfg_has_abort = 1'b1; cfg_abort_n = 7;   run_one();
    set_default(); cfg_has_abort = 1'b1; cfg_abort_n = -3;  run_one();
    set_default(); cfg_has_abort = 1'b1; cfg_abort_n = -1;  run_one();
    set_default(); cfg_lim = 24; cfg_first = 20;            run_one();
    set_default(); cfg_start_abort = 1'b1; cfg_first = 5;   run_one();
    set_default(); cfg_start_p = 8; cfg_first = 3;          run_one();
    set_default(); cfg_has_abort = 1'b1; cfg_abort_n = 10000; run_one();

    // Asynchronous reset in the middle of RUN, between clock edges.
    set_default();
    start         = 1'b1;
    timeout_limit = '0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (RC + 12) @(posedge clock);
    #1;
    chk("pre_reset_execute", 64'(block_execute), 64'(1));
    #2 reset = 1'b0;
    #1 check_all_zero("async");
    @(posedge clock); #1;
    check_all_zero("held");
    reset = 1'b1;
    @(posedge clock); #1;
    set_default(); cfg_first = 20; run_one();

    // Randomised runs.
    for (int r = 0; r < 40; r++) begin
      set_default();
      cfg_mode1 = 1'($urandom_range(0, 1));
      if (cfg_mode1) begin
        for (int i = 0; i < 256; i++) rbits[i] = ($urandom_range(0, 9) < 7);
      end else begin
        cfg_first  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 100)) : NEVER;
        cfg_glitch = int'($urandom_range(0, 120));
      end
      cfg_lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120));
      if ($urandom_range(0, 4) == 0) begin
        cfg_has_abort = 1'b1;
        cfg_abort_n   = int'($urandom_range(0, 60)) - 5;
      end
      if ($urandom_range(0, 3) == 0) cfg_start_p = int'($urandom_range(0, 20));
      cfg_start_abort = ($urandom_range(0, 3) == 0);
      run_one();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/block_execution_controller.md
Name: block_execution_controller

Overview:
Run-sequencing stage directly upstream of the TIA block's control pins. It drives block_reset, block_enable and block_execute. It then waits for halted plus channel and router quiescence to hold stably, and reports completion, timeout or abort to the host-side control register file. Its outputs feed the block's reset, enable and execute inputs, which the block buffers by one more cycle internally.

Parameters:
COUNTER_WIDTH, 32, width of timeout_limit and cycle_count.
RESET_CYCLES, 4, cycles block_reset is held high per run (≥2).
SETTLE_CYCLES, 4, consecutive cycles halted && channels_quiescent && routers_quiescent must all be high before completion (≥1; covers block-side register latency).

Ports:
clock  input  1  positive-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a run.
abort  input  1  one-cycle request to terminate a run.
timeout_limit  input  COUNTER_WIDTH  max RUN cycles; 0 = no timeout; sampled when start is accepted.
block_reset  output  1  active-high reset to block.
block_enable  output  1  enable to block.
block_execute  output  1  execute to block.
block_halted  input  1  block halted status.
block_channels_quiescent  input  1  block channel-buffer-empty status.
block_routers_quiescent  input  1  block router-buffer-empty status.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse at end of run.
status  output  2  00 none, 01 completed, 10 timeout, 11 aborted.
cycle_count  output  COUNTER_WIDTH  cycles spent in RUN for the current or last run.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - state=IDLE.
  - All outputs 0: block_reset, block_enable, block_execute, busy, done, status, cycle_count.
  - Internal counters 0.
- All outputs are flop outputs; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, RESET_BLOCK, ARM, RUN, FINISH.
- IDLE:
  - start=1 at edge → RESET_BLOCK.
  - On that same edge: latch timeout_limit, cycle_count←0, status←00.
  - abort in IDLE is ignored.
- RESET_BLOCK:
  - block_reset=1, block_enable=0, block_execute=0.
  - Held exactly RESET_CYCLES cycles, then → ARM.
- ARM:
  - Exactly 1 cycle.
  - block_reset=0, block_enable=1, block_execute=0.
  - Then → RUN.
- RUN:
  - block_enable=1, block_execute=1.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Settle counter increments when all three status inputs are 1; it clears to 0 when any is 0.
- Exit from RUN, in priority order on the same edge:
  - (1) abort=1 → FINISH, status←11.
  - (2) settle counter reaches SETTLE_CYCLES → FINISH, status←01.
  - (3) latched limit≠0 and cycle_count reaches limit → FINISH, status←10.
  - Completion beats timeout when both happen on the same edge.
- abort in RESET_BLOCK or ARM → FINISH, status←11.
- FINISH:
  - Exactly 1 cycle: block_execute=0, done=1, then → IDLE.
  - block_enable stays 1 through FINISH and afterwards in IDLE, so the host can access block memories.
  - block_enable is cleared only by reset or by entering RESET_BLOCK.
- status and cycle_count hold their values in IDLE until the next accepted start.
- start while busy=1 is ignored.
- Latency, with start sampled at edge E:
  - block_reset high for cycles E+1..E+RESET_CYCLES.
  - ARM at cycle E+RESET_CYCLES+1.
  - block_execute first high at cycle E+RESET_CYCLES+2.
- Reset mid-run: immediate return to IDLE with all outputs 0. There is no done pulse.

Test Plan:
- Normal run (RESET_CYCLES=4, SETTLE_CYCLES=4, limit=0): start, status inputs high from RUN cycle 20 → block_reset high 4 cycles, ARM 1 cycle, done pulse 1 cycle, status=01, cycle_count=24, block_execute low in FINISH, block_enable remains 1.
- Settle glitch: all inputs high RUN cycles 10–12, routers_quiescent low cycle 13, all high from 14 → completion at cycle_count=18, status=01.
- Timeout: limit=100, inputs never all high → done after RUN cycle 100, status=10, cycle_count=100. Repeat with limit=0 for 10000 cycles → no done, busy stays 1.
- Abort: abort at RUN cycle 7 → next cycle FINISH, done=1, status=11, cycle_count=8. Abort during RESET_BLOCK → FINISH after that edge, status=11.
- Async reset: assert reset low mid-RUN between clock edges → all outputs 0 before next edge. Release, start again → normal sequence.
- Races: start while busy → ignored, no restart. limit=24 with inputs high from RUN cycle 20 (completion and timeout coincide) → status=01. start and abort together in IDLE → run begins.
